// File: rtl/constraint_sample_sched.sv
// constraint_sample_sched: drives pseudo-random candidates into a constraint
// checker, samples its verdict after a fixed latency, and streams satisfying
// candidates out until the target count, the attempt budget or an abort ends
// the run.
module constraint_sample_sched #(
  parameter int CAND_W  = 185,
  parameter int WORD_W  = 32,
  parameter int CHK_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       seed,
  input  logic [CNT_W-1:0]  target,
  input  logic [31:0]       max_tries,
  output logic [CAND_W-1:0] cand_o,
  input  logic              chk_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CAND_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  found_cnt,
  output logic [31:0]       tries_cnt
);

  localparam int NW = (CAND_W + WORD_W - 1) / WORD_W;
  localparam int FW = (NW > 1) ? $clog2(NW) : 1;
  localparam int EW = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, FILL, EVAL, EMIT, DONE} state_t;

  // xorshift32 step: shifts 13, 17, 5
  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  state_t                     state, state_d;
  logic [31:0]                lfsr;
  logic [31:0]                lfsr_nx;
  logic [CAND_W+31:0]         shifted;
  logic [FW-1:0]              fill_cnt;
  logic [EW-1:0]              eval_cnt;
  logic                       fill_last, eval_last;
  logic                       run_init, gen_step, sample, handshake;
  logic                       set_timeout, abort_take;
  logic [31:0]                tries_nx;
  logic [CNT_W-1:0]           found_nx;
  logic                       budget_now, budget_nx;

  assign lfsr_nx    = xs32(lfsr);
  assign shifted    = {cand_o, lfsr_nx};
  assign fill_last  = (fill_cnt == FW'(NW - 1));
  assign eval_last  = (eval_cnt == EW'(CHK_LAT));
  assign tries_nx   = (tries_cnt == 32'hFFFF_FFFF) ? tries_cnt : tries_cnt + 32'd1;
  assign found_nx   = found_cnt + CNT_W'(1);
  assign budget_now = (max_tries != 32'd0) && (tries_cnt == max_tries);
  assign budget_nx  = (max_tries != 32'd0) && (tries_nx == max_tries);
  // The candidate register only moves in FILL, so it doubles as the solution.
  assign out_data   = cand_o;

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d     = state;
    run_init    = 1'b0;
    gen_step    = 1'b0;
    sample      = 1'b0;
    handshake   = 1'b0;
    set_timeout = 1'b0;
    abort_take  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && abort) begin
          abort_take = 1'b1;
          state_d    = IDLE;
        end else if (start) begin
          run_init = 1'b1;
          state_d  = (target == '0) ? DONE : FILL;
        end else begin
          state_d = state;
        end
      end
      FILL: begin
        if (abort) begin
          abort_take = 1'b1;
          state_d    = IDLE;
        end else begin
          gen_step = 1'b1;
          state_d  = fill_last ? EVAL : FILL;
        end
      end
      EVAL: begin
        if (abort) begin
          abort_take = 1'b1;
          state_d    = IDLE;
        end else if (eval_last) begin
          sample = 1'b1;
          if (chk_x) begin
            state_d = EMIT;
          end else if (budget_nx) begin
            set_timeout = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = EVAL;
        end
      end
      EMIT: begin
        if (abort) begin
          abort_take = 1'b1;
          state_d    = IDLE;
        end else if (out_ready) begin
          handshake = 1'b1;
          if (found_nx == target) begin
            state_d = DONE;
          end else if (budget_now) begin
            set_timeout = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and state-derived status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= (state_d == FILL) || (state_d == EVAL) || (state_d == EMIT);
      done      <= (state_d == DONE);
      out_valid <= (state_d == EMIT);
    end
  end

  // Generator state and candidate shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= 32'h1;
      cand_o <= '0;
    end else if (run_init) begin
      lfsr <= (seed == 32'd0) ? 32'h1 : seed;
    end else if (gen_step) begin
      lfsr   <= lfsr_nx;
      cand_o <= shifted[CAND_W-1:0];
    end
  end

  // FILL word counter and EVAL latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
      eval_cnt <= '0;
    end else begin
      fill_cnt <= (gen_step && !fill_last) ? fill_cnt + FW'(1) : '0;
      eval_cnt <= ((state == EVAL) && !abort && !eval_last) ? eval_cnt + EW'(1) : '0;
    end
  end

  // Per-run solution/attempt counters and budget-exhaustion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_cnt <= '0;
      tries_cnt <= 32'd0;
      timeout   <= 1'b0;
    end else if (run_init) begin
      found_cnt <= '0;
      tries_cnt <= 32'd0;
      timeout   <= 1'b0;
    end else begin
      if (sample)    tries_cnt <= tries_nx;
      if (handshake) found_cnt <= found_nx;
      if (set_timeout)     timeout <= 1'b1;
      else if (abort_take) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_constraint_sample_sched.sv
// Scoreboard bench for constraint_sample_sched: a run-level reference model
// predicts the solutions and final counters; a monitor checks every handshake.
module tb_constraint_sample_sched;
  localparam int CAND_W = 185;
  localparam int CNT_W  = 16;
  localparam int NW     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0;
  logic [31:0]       seed = 32'd0;
  logic [CNT_W-1:0]  target = '0;
  logic [31:0]       max_tries = 32'd0;
  logic [CAND_W-1:0] cand_o, out_data;
  logic              chk_x, out_valid, busy, done, timeout;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  found_cnt;
  logic [31:0]       tries_cnt;

  constraint_sample_sched #(.CAND_W(CAND_W), .WORD_W(32), .CHK_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .target(target), .max_tries(max_tries), .cand_o(cand_o), .chk_x(chk_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .timeout(timeout), .found_cnt(found_cnt),
    .tries_cnt(tries_cnt));

  always #5 clk = ~clk;

  int npass = 0, ntotal = 0;
  logic [CAND_W-1:0] sb[$];
  int chk_mode = 0;            // 0 never, 1 always, 2 low byte < thresh, 3 equals special
  int thresh = 0;
  logic [CAND_W-1:0] special = '0;
  int rdy_mode = 0;            // 0 ready high, 1 random, 2 driven by the test
  logic valid_seen = 1'b0;
  int exp_found;
  logic [31:0] exp_tries;
  logic exp_timeout;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13); t = t ^ (t >> 17); t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic chk_f(input logic [CAND_W-1:0] c);
    case (chk_mode)
      1: return 1'b1;
      2: return (int'(c[7:0]) < thresh);
      3: return (c == special);
      default: return 1'b0;
    endcase
  endfunction

  // Candidate n (1-based) produced by a run started with seed sd
  function automatic logic [CAND_W-1:0] cand_nth(input logic [31:0] sd, input int n);
    logic [31:0] s; logic [CAND_W+31:0] t; logic [CAND_W-1:0] c;
    s = (sd == 32'd0) ? 32'h1 : sd; c = '0;
    for (int k = 0; k < n; k++)
      for (int w = 0; w < NW; w++) begin s = xs(s); t = {c, s}; c = t[CAND_W-1:0]; end
    return c;
  endfunction

  // Whole-run reference model: pushes expected solutions, sets final counters
  task automatic model_run(input logic [31:0] sd, input int tgt, input logic [31:0] mt);
    logic [CAND_W-1:0] c; int fd; logic [31:0] tr; int guard;
    fd = 0; tr = 32'd0; exp_timeout = 1'b0; guard = 0;
    if (tgt != 0) begin
      while (guard < 2000) begin
        guard++;
        c = cand_nth(sd, guard);
        tr = tr + 32'd1;
        if (chk_f(c)) begin
          sb.push_back(c); fd++;
          if (fd == tgt) break;
        end
        if (mt != 32'd0 && tr == mt) begin exp_timeout = 1'b1; break; end
      end
    end
    exp_found = fd; exp_tries = tr;
  endtask

  // Fixed-latency (1 cycle) checker model
  logic chk_pipe;
  always @(posedge clk or posedge rst) begin
    if (rst) chk_pipe <= 1'b0;
    else     chk_pipe <= chk_f(cand_o);
  end
  assign chk_x = chk_pipe;

  // Consumer ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability
  initial begin
    logic stall_q; logic [CAND_W-1:0] data_q; logic [CAND_W-1:0] e;
    stall_q = 1'b0; data_q = '0;
    forever begin
      @(negedge clk);
      if (out_valid) valid_seen = 1'b1;
      if (stall_q && out_valid) chk("hold_data", out_data, data_q);
      if (out_valid && out_ready && !abort) begin
        if (sb.size() == 0) begin
          ntotal++;
          $display("FAIL sb_underflow actual=%0h required=none", out_data);
        end else begin
          e = sb.pop_front();
          chk("sol_data", out_data, e);
        end
      end
      stall_q = out_valid && !out_ready && !rst;
      data_q  = out_data;
    end
  end

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (!done && n < 8000) begin @(posedge clk); #1; n++; end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_timeout"}, timeout, exp_timeout);
    chk({tag, "_found"}, found_cnt, exp_found);
    chk({tag, "_tries"}, tries_cnt, exp_tries);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic setup(input logic [31:0] sd, input int tgt, input logic [31:0] mt);
    seed = sd; target = CNT_W'(tgt); max_tries = mt;
    model_run(sd, tgt, mt);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid_seen"}, out_valid, 1'b1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n; logic [31:0] w0; logic [CAND_W-1:0] e;
    // Reset state
    #22;
    chk("rst_valid", out_valid, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0); chk("rst_timeout", timeout, 1'b0);
    chk("rst_found", found_cnt, 0); chk("rst_tries", tries_cnt, 0);
    chk("rst_cand", cand_o, 0); chk("rst_data", out_data, 0);
    @(negedge clk); rst = 1'b0;

    // Seed 1, always-pass checker, target 1: latency and first word
    chk_mode = 1; rdy_mode = 0;
    setup(32'd1, 1, 32'd0);
    start_pulse();
    n = 1;
    while (!out_valid && n < 50) begin
      if (n == 2) begin w0 = cand_o[31:0]; chk("first_word", w0, 32'h0004_2021); end
      @(posedge clk); #1; n++;
    end
    chk("valid_latency", n, 9);
    finish_run("t1");

    // Never-pass checker, budget 5
    chk_mode = 0; valid_seen = 1'b0;
    setup(32'hACE1_2345, 2, 32'd5);
    start_pulse();
    finish_run("budget");
    chk("budget_no_valid", valid_seen, 1'b0);

    // Consumer stalls 10 cycles in the first EMIT
    chk_mode = 1; rdy_mode = 2; out_ready = 1'b0;
    setup(32'd7, 3, 32'd0);
    start_pulse();
    wait_valid("stall");
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, e);
      chk("stall_cand", cand_o, e);
    end
    rdy_mode = 0;
    finish_run("stall");

    // Pass exactly on the 4th try with a budget of 4: target wins
    chk_mode = 3; special = cand_nth(32'd1, 4);
    setup(32'd1, 1, 32'd4);
    start_pulse();
    finish_run("prio");

    // Abort together with out_ready during EMIT
    chk_mode = 1; rdy_mode = 2; out_ready = 1'b0;
    setup(32'd99, 3, 32'd0);
    start_pulse();
    wait_valid("abort");
    @(posedge clk); #1 abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 abort = 1'b0; out_ready = 1'b0;
    chk("abort_valid", out_valid, 1'b0); chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0); chk("abort_timeout", timeout, 1'b0);
    chk("abort_found", found_cnt, 0); chk("abort_tries", tries_cnt, 1);
    sb.delete();
    rdy_mode = 0;

    // Zero seed behaves as seed 1
    chk_mode = 3; special = cand_nth(32'd1, 2);
    setup(32'd0, 1, 32'd0);
    start_pulse();
    finish_run("seed0");

    // target 0: done right after start
    setup(32'd5, 0, 32'd0);
    start_pulse();
    chk("tgt0_done", done, 1'b1); chk("tgt0_tries", tries_cnt, 0);
    chk("tgt0_busy", busy, 1'b0); chk("tgt0_timeout", timeout, 1'b0);

    // Randomized runs with a random-ready consumer
    for (int r = 0; r < 8; r++) begin
      logic [31:0] sd; int tg; logic [31:0] mt;
      chk_mode = 2; thresh = $urandom_range(40, 120); rdy_mode = 1;
      sd = $urandom; tg = $urandom_range(1, 4);
      mt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 12)) : 32'd0;
      setup(sd, tg, mt);
      start_pulse();
      finish_run("rand");
    end

    // Asynchronous reset in the middle of a run
    chk_mode = 1; rdy_mode = 0;
    setup(32'd3, 3, 32'd0);
    start_pulse();
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0); chk("arst_cand", cand_o, 0);
    chk("arst_valid", out_valid, 1'b0); chk("arst_tries", tries_cnt, 0);
    chk("arst_found", found_cnt, 0); chk("arst_done", done, 1'b0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
